// File: rtl/retire_trace_fifo.sv
// Retired-instruction trace FIFO: buffers WB-stage commit records and streams them
// first-word-fall-through over valid/ready. Optional record limit: RETIRE_TRACE_LIMIT_EN.
module retire_trace_fifo #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int MAX_RECORDS = 5000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          commit_valid,
    input  logic [31:0]   commit_pc,
    input  logic [31:0]   commit_inst,
    input  logic          commit_wen,
    input  logic [4:0]    commit_waddr,
    input  logic [31:0]   commit_wdata,
    output logic          trace_valid,
    input  logic          trace_ready,
    output logic [31:0]   trace_pc,
    output logic [31:0]   trace_inst,
    output logic          trace_wen,
    output logic [4:0]    trace_waddr,
    output logic [31:0]   trace_wdata,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic [15:0]   drop_cnt,
    output logic          trace_done
);

    localparam int LW = AW + 1;
    localparam logic [AW:0] FULL_LEVEL = LW'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } record_t;

    record_t       mem [DEPTH];
    record_t       head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_q;
    logic          full;
    logic          accept;
    logic          push;
    logic          pop;
    logic          drop;
    logic          done;

    assign full   = (level_q == FULL_LEVEL);
    assign accept = commit_valid && (commit_pc != '0) && !done;
    assign pop    = (level_q != '0) && trace_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push   = accept && (!full || pop);
    assign drop   = accept && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: commit_pc, inst: commit_inst, wen: commit_wen,
                             waddr: commit_waddr, wdata: commit_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

`ifdef RETIRE_TRACE_LIMIT_EN
    logic [31:0] accepted;

    always_ff @(posedge clk) begin
        if (reset) begin
            accepted <= '0;
            done     <= 1'b0;
        end else if (push) begin
            accepted <= accepted + 32'd1;
            if (accepted + 32'd1 == 32'(MAX_RECORDS)) done <= 1'b1;
        end
    end
`else
    assign done = 1'b0 && (MAX_RECORDS != 0);
`endif

    assign trace_done  = done;
    assign level       = level_q;
    assign trace_valid = (level_q != '0);
    assign head        = trace_valid ? mem[rd_ptr] : '0;
    assign trace_pc    = head.pc;
    assign trace_inst  = head.inst;
    assign trace_wen   = head.wen;
    assign trace_waddr = head.waddr;
    assign trace_wdata = head.wdata;

endmodule
